// File: rtl/maze_pkg.sv
// Shared constants and types for the maze walker and the renderer.
package maze_pkg;

    localparam int CELL_W  = 32;
    localparam int CELL_H  = 30;
    localparam int COLS    = 20;
    localparam int ROWS    = 16;
    localparam int DEATH_W = 8;

    localparam int COL_W = 5;
    localparam int ROW_W = 4;
    localparam int PX_W  = 10;
    localparam int PY_W  = 9;

    typedef enum logic [2:0] {
        RES_MOVED    = 3'd0,
        RES_BLOCKED  = 3'd1,
        RES_LAVA     = 3'd2,
        RES_TELEPORT = 3'd3,
        RES_WIN      = 3'd4,
        RES_OFFGRID  = 3'd5
    } result_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_EVAL  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        TP_PINK   = 3'd0,
        TP_GREEN  = 3'd1,
        TP_CYAN   = 3'd2,
        TP_PURPLE = 3'd3,
        TP_GREY   = 3'd4
    } tp_colour_e;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } cell_t;

    typedef struct packed {
        logic wall;
        logic lava;
        logic finish;
        logic start;
        logic pink;
        logic green;
        logic cyan;
        logic purple;
        logic grey;
    } map_flags_t;

    localparam cell_t START_CELL  = '{col: 5'd0,  row: 4'd0};
    localparam cell_t FINISH_CELL = '{col: 5'd17, row: 4'd13};

    // Each teleport colour joins exactly two cells; stepping onto one end
    // lands the player on the other end.
    function automatic cell_t tp_partner(input tp_colour_e colour, input cell_t cand);
        cell_t end_a;
        cell_t end_b;
        case (colour)
            TP_PINK: begin
                end_a = '{col: 5'd7,  row: 4'd5};
                end_b = '{col: 5'd13, row: 4'd1};
            end
            TP_GREEN: begin
                end_a = '{col: 5'd13, row: 4'd3};
                end_b = '{col: 5'd1,  row: 4'd8};
            end
            TP_CYAN: begin
                end_a = '{col: 5'd0,  row: 4'd15};
                end_b = '{col: 5'd8,  row: 4'd8};
            end
            TP_PURPLE: begin
                end_a = '{col: 5'd9,  row: 4'd8};
                end_b = '{col: 5'd11, row: 4'd14};
            end
            TP_GREY: begin
                end_a = '{col: 5'd17, row: 4'd12};
                end_b = '{col: 5'd17, row: 4'd14};
            end
            default: begin
                end_a = START_CELL;
                end_b = START_CELL;
            end
        endcase
        return (cand == end_a) ? end_b : end_a;
    endfunction

endpackage

// File: rtl/cell_to_pixel.sv
// Grid cell to centre pixel. CELL_W = 32 is a plain shift; CELL_H = 30 is
// built as row*32 - row*2 so no multiplier is inferred.
module cell_to_pixel
    import maze_pkg::*;
(
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    output logic [PX_W-1:0]  px,
    output logic [PY_W-1:0]  py
);

    assign px = {col, 5'd0} + PX_W'(CELL_W / 2);
    assign py = {row, 5'd0} - {4'd0, row, 1'b0} + PY_W'(CELL_H / 2);

endmodule

// File: rtl/maze_walker.sv
// Player position owner: turns direction requests into map probes and
// resolves each probe into a move outcome.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; probe shows the player's own cell
// ST_PROBE | candidate probe on the map bus; flags captured at cycle end
// ST_EVAL  | resolve captured flags, update position, pulse move_done
module maze_walker
    import maze_pkg::*;
#(
    parameter int DEATH_W = maze_pkg::DEATH_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         move_req,
    input  logic               restart,
    input  logic               walls,
    input  logic               lava_pits,
    input  logic               teleport_pink,
    input  logic               teleport_green,
    input  logic               teleport_cyan,
    input  logic               teleport_purple,
    input  logic               teleport_grey,
    input  logic               start_line,
    input  logic               finish_line,
    output logic [PX_W-1:0]    probe_x,
    output logic [PY_W-1:0]    probe_y,
    output logic [COL_W-1:0]   player_col,
    output logic [ROW_W-1:0]   player_row,
    output logic               busy,
    output logic               move_done,
    output result_e            result,
    output logic               won,
    output logic [DEATH_W-1:0] deaths
);

    state_e             state_q, state_d;
    cell_t              pos_q, pos_d;
    cell_t              cand_q, cand_d;
    map_flags_t         flags_q, flags_d;
    logic [PX_W-1:0]    probe_x_q, probe_x_d;
    logic [PY_W-1:0]    probe_y_q, probe_y_d;
    logic               move_done_q, move_done_d;
    result_e            result_q, result_d;
    logic               won_q, won_d;
    logic [DEATH_W-1:0] deaths_q, deaths_d;

    cell_t              req_cell;
    logic               req_off;
    tp_colour_e         tp_sel;
    cell_t              tp_dst;
    cell_t              pix_cell;
    logic [PX_W-1:0]    pix_x;
    logic [PY_W-1:0]    pix_y;
    map_flags_t         flags_in;

    // The start line needs no action here; it is captured only so all map
    // flags travel together.
    logic               start_flag_unused;
    assign start_flag_unused = flags_q.start;

    assign flags_in = '{wall: walls, lava: lava_pits, finish: finish_line,
                        start: start_line, pink: teleport_pink,
                        green: teleport_green, cyan: teleport_cyan,
                        purple: teleport_purple, grey: teleport_grey};

    // Candidate cell for the highest-priority requested direction.
    always_comb begin
        req_cell = pos_q;
        req_off  = 1'b0;
        if (move_req[3]) begin
            req_off      = (pos_q.row == '0);
            req_cell.row = pos_q.row - 4'd1;
        end else if (move_req[2]) begin
            req_off      = (pos_q.row == ROW_W'(ROWS - 1));
            req_cell.row = pos_q.row + 4'd1;
        end else if (move_req[1]) begin
            req_off      = (pos_q.col == '0);
            req_cell.col = pos_q.col - 5'd1;
        end else begin
            req_off      = (pos_q.col == COL_W'(COLS - 1));
            req_cell.col = pos_q.col + 5'd1;
        end
    end

    // Teleport colour choice when more than one flag is up, and its landing cell.
    always_comb begin
        tp_sel = TP_PINK;
        if (flags_q.pink)        tp_sel = TP_PINK;
        else if (flags_q.green)  tp_sel = TP_GREEN;
        else if (flags_q.cyan)   tp_sel = TP_CYAN;
        else if (flags_q.purple) tp_sel = TP_PURPLE;
        else if (flags_q.grey)   tp_sel = TP_GREY;
        tp_dst = tp_partner(tp_sel, cand_q);
    end

    // Next-state, position and result resolution.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        cand_d      = cand_q;
        flags_d     = flags_q;
        move_done_d = 1'b0;
        result_d    = result_q;
        won_d       = won_q;
        deaths_d    = deaths_q;
        pix_cell    = pos_q;

        if (restart) begin
            state_d  = ST_IDLE;
            pos_d    = START_CELL;
            won_d    = 1'b0;
            pix_cell = START_CELL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((move_req != 4'd0) && !won_q) begin
                        if (req_off) begin
                            move_done_d = 1'b1;
                            result_d    = RES_OFFGRID;
                        end else begin
                            cand_d   = req_cell;
                            pix_cell = req_cell;
                            state_d  = ST_PROBE;
                        end
                    end
                end
                ST_PROBE: begin
                    flags_d  = flags_in;
                    pix_cell = cand_q;
                    state_d  = ST_EVAL;
                end
                ST_EVAL: begin
                    if (flags_q.wall) begin
                        result_d = RES_BLOCKED;
                    end else if (flags_q.lava) begin
                        pos_d    = START_CELL;
                        deaths_d = (deaths_q == '1) ? deaths_q : deaths_q + DEATH_W'(1);
                        result_d = RES_LAVA;
                    end else if (flags_q.finish) begin
                        pos_d    = cand_q;
                        won_d    = 1'b1;
                        result_d = RES_WIN;
                    end else if (flags_q.pink || flags_q.green || flags_q.cyan ||
                                 flags_q.purple || flags_q.grey) begin
                        pos_d    = tp_dst;
                        result_d = RES_TELEPORT;
                    end else begin
                        pos_d    = cand_q;
                        result_d = RES_MOVED;
                    end
                    move_done_d = 1'b1;
                    pix_cell    = pos_d;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        probe_x_d = pix_x;
        probe_y_d = pix_y;
    end

    cell_to_pixel u_cell_to_pixel (
        .col (pix_cell.col),
        .row (pix_cell.row),
        .px  (pix_x),
        .py  (pix_y)
    );

    // State and output registers; reset probe is the centre of the start cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= START_CELL;
            cand_q      <= START_CELL;
            flags_q     <= '0;
            probe_x_q   <= PX_W'(CELL_W / 2);
            probe_y_q   <= PY_W'(CELL_H / 2);
            move_done_q <= 1'b0;
            result_q    <= RES_MOVED;
            won_q       <= 1'b0;
            deaths_q    <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            cand_q      <= cand_d;
            flags_q     <= flags_d;
            probe_x_q   <= probe_x_d;
            probe_y_q   <= probe_y_d;
            move_done_q <= move_done_d;
            result_q    <= result_d;
            won_q       <= won_d;
            deaths_q    <= deaths_d;
        end
    end

    assign probe_x    = probe_x_q;
    assign probe_y    = probe_y_q;
    assign player_col = pos_q.col;
    assign player_row = pos_q.row;
    assign busy       = (state_q != ST_IDLE);
    assign move_done  = move_done_q;
    assign result     = result_q;
    assign won        = won_q;
    assign deaths     = deaths_q;

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker with a small map model and result scoreboard.
module tb_maze_walker;
    import maze_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  move_req;
    logic        restart;
    logic [8:0]  map_f;
    logic [9:0]  probe_x;
    logic [8:0]  probe_y;
    logic [4:0]  player_col;
    logic [3:0]  player_row;
    logic        busy;
    logic        move_done;
    result_e     result;
    logic        won;
    logic [7:0]  deaths;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    int m_col = 0;
    int m_row = 0;
    int m_deaths = 0;
    int m_won = 0;

    typedef struct {
        int res;
        int col;
        int row;
        int deaths;
        int won;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    maze_walker #(.DEATH_W(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .move_req        (move_req),
        .restart         (restart),
        .walls           (map_f[8]),
        .lava_pits       (map_f[7]),
        .finish_line     (map_f[6]),
        .start_line      (map_f[5]),
        .teleport_pink   (map_f[4]),
        .teleport_green  (map_f[3]),
        .teleport_cyan   (map_f[2]),
        .teleport_purple (map_f[1]),
        .teleport_grey   (map_f[0]),
        .probe_x         (probe_x),
        .probe_y         (probe_y),
        .player_col      (player_col),
        .player_row      (player_row),
        .busy            (busy),
        .move_done       (move_done),
        .result          (result),
        .won             (won),
        .deaths          (deaths)
    );

    // Map: {wall, lava, finish, start, pink, green, cyan, purple, grey}
    function automatic logic [8:0] map_at(input int c, input int r);
        logic [8:0] f;
        f    = '0;
        f[8] = (c == 1  && r == 0);
        f[7] = (c == 0  && r == 7);
        f[6] = (c == 17 && r == 13);
        f[5] = (c == 0  && r == 0);
        f[4] = (c == 7  && r == 5) || (c == 13 && r == 1);
        return f;
    endfunction

    always_comb map_f = map_at(int'(probe_x) / 32, int'(probe_y) / 30);

    always @(negedge clk) if (move_done === 1'b1) done_cnt = done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_px"},   32'(probe_x), 32'd16);
        chk({tag, "_py"},   32'(probe_y), 32'd15);
        chk({tag, "_col"},  32'(player_col), 32'd0);
        chk({tag, "_row"},  32'(player_row), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(move_done), 32'd0);
        chk({tag, "_res"},  32'(result), 32'd0);
        chk({tag, "_won"},  32'(won), 32'd0);
        chk({tag, "_dth"},  32'(deaths), 32'd0);
    endtask

    // One request: model the outcome, push it, drive, then check latency and pop.
    task automatic do_move(input logic [3:0] req, input string tag);
        int cc, cr, lat, exp_lat, epx, epy;
        bit off;
        logic [8:0] f;
        exp_t e, got;
        cc = m_col;
        cr = m_row;
        if (req[3])      cr = cr - 1;
        else if (req[2]) cr = cr + 1;
        else if (req[1]) cc = cc - 1;
        else             cc = cc + 1;
        off = (cr < 0) || (cr > 15) || (cc < 0) || (cc > 19);
        if (off) begin
            e = '{5, m_col, m_row, m_deaths, m_won};
            epx = m_col * 32 + 16;
            epy = m_row * 30 + 15;
            exp_lat = 0;
        end else begin
            f = map_at(cc, cr);
            epx = cc * 32 + 16;
            epy = cr * 30 + 15;
            exp_lat = 2;
            if (f[8])      e = '{1, m_col, m_row, m_deaths, m_won};
            else if (f[7]) e = '{2, 0, 0, (m_deaths < 255) ? m_deaths + 1 : 255, m_won};
            else if (f[6]) e = '{4, cc, cr, m_deaths, 1};
            else if (f[4]) e = (cc == 7 && cr == 5) ? '{3, 13, 1, m_deaths, m_won}
                                                    : '{3, 7, 5, m_deaths, m_won};
            else           e = '{0, cc, cr, m_deaths, m_won};
        end
        sb.push_back(e);
        m_col = e.col; m_row = e.row; m_deaths = e.deaths; m_won = e.won;

        @(negedge clk);
        move_req = req;
        @(posedge clk); #1;
        move_req = 4'd0;
        chk({tag, "_probe_x"}, 32'(probe_x), 32'(epx));
        chk({tag, "_probe_y"}, 32'(probe_y), 32'(epy));
        lat = 0;
        while (move_done !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done"}, 32'(move_done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk({tag, "_res"},  32'(result), 32'(got.res));
            chk({tag, "_col"},  32'(player_col), 32'(got.col));
            chk({tag, "_row"},  32'(player_row), 32'(got.row));
            chk({tag, "_dth"},  32'(deaths), 32'(got.deaths));
            chk({tag, "_won"},  32'(won), 32'(got.won));
            chk({tag, "_home_x"}, 32'(probe_x), 32'(got.col * 32 + 16));
            chk({tag, "_home_y"}, 32'(probe_y), 32'(got.row * 30 + 15));
        end
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(move_done), 32'd0);
    endtask

    initial begin
        int dc;
        move_req = 4'd0;
        restart  = 1'b0;
        reset_n  = 1'b1;
        #2 reset_n = 1'b0;
        #20;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_move(4'b1000, "offgrid_up");
        do_move(4'b0001, "wall_right");

        for (int i = 0; i < 7; i++) do_move(4'b0100, "down_to_lava");
        chk("lava_deaths", 32'(deaths), 32'd1);
        chk("lava_col", 32'(player_col), 32'd0);
        chk("lava_row", 32'(player_row), 32'd0);

        for (int i = 0; i < 4; i++) do_move(4'b0100, "down_to_r4");
        for (int i = 0; i < 7; i++) do_move(4'b0001, "right_to_c7");
        chk("at_7_4", {27'd0, player_col}, 32'd7);

        dc = done_cnt;
        do_move(4'b0100, "tele_pink");
        repeat (3) @(posedge clk);
        #1 chk("tele_one_pulse", 32'(done_cnt - dc), 32'd1);
        chk("tele_col", 32'(player_col), 32'd13);
        chk("tele_row", 32'(player_row), 32'd1);

        for (int i = 0; i < 4; i++)  do_move(4'b0001, "right_to_c17");
        for (int i = 0; i < 12; i++) do_move(4'b0100, "down_to_finish");
        chk("win_flag", 32'(won), 32'd1);

        dc = done_cnt;
        @(negedge clk);
        move_req = 4'b1000;
        @(negedge clk);
        move_req = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("won_ignore_px", 32'(probe_x), 32'd560);
        chk("won_ignore_py", 32'(probe_y), 32'd405);
        chk("won_ignore_row", 32'(player_row), 32'd13);
        chk("won_ignore_busy", 32'(busy), 32'd0);
        chk("won_ignore_done", 32'(done_cnt - dc), 32'd0);

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_col", 32'(player_col), 32'd0);
        chk("restart_row", 32'(player_row), 32'd0);
        chk("restart_won", 32'(won), 32'd0);
        chk("restart_deaths", 32'(deaths), 32'd1);
        chk("restart_px", 32'(probe_x), 32'd16);
        m_col = 0; m_row = 0; m_won = 0;

        do_move(4'b0100, "down_to_r1");
        dc = done_cnt;
        @(negedge clk);
        move_req = 4'b1111;
        @(posedge clk); #1;
        move_req = 4'd0;
        chk("prio_up_px", 32'(probe_x), 32'd16);
        chk("prio_up_py", 32'(probe_y), 32'd15);
        chk("prio_busy", 32'(busy), 32'd1);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_col", 32'(player_col), 32'd0);
        chk("abort_row", 32'(player_row), 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        chk("abort_result_held", 32'(result), 32'd0);
        m_col = 0; m_row = 0;

        do_move(4'b0100, "down_again");
        @(negedge clk);
        move_req = 4'b0100;
        @(posedge clk); #1;
        move_req = 4'd0;
        chk("mid_probe_py", 32'(probe_y), 32'd75);
        @(posedge clk); #1;
        chk("mid_eval_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        m_col = 0; m_row = 0; m_deaths = 0; m_won = 0;
        sb.delete();

        do_move(4'b0001, "post_reset_wall");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maze_walker.md
Name: maze_walker

Overview:
- Sequential client of the maze map lookup. It owns the player's grid position and turns direction requests into map probes.
- For each request it drives a probe pixel (probe_x/probe_y) at the candidate cell centre. One cycle later it samples the map classification flags and resolves the move: moved, blocked, lava (respawn), teleport (jump to partner), or win.
- Sits between the input debouncer/controller and the VGA renderer. The renderer reads player_col/player_row.

Parameters:
CELL_W, 32, cell width in pixels
CELL_H, 30, cell height in pixels
COLS, 20, grid columns (0..19)
ROWS, 16, grid rows (0..15)
DEATH_W, 8, death counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
move_req  in  4  {up,down,left,right}, sampled only in IDLE
restart  in  1  synchronous return to start; clears won
walls, lava_pits, teleport_pink, teleport_green, teleport_cyan, teleport_purple, teleport_grey, start_line, finish_line  in  1 each  map flags for the current probe
probe_x  out  10  probe pixel x (registered)
probe_y  out  9  probe pixel y (registered)
player_col  out  5  current column
player_row  out  4  current row
busy  out  1  high in PROBE/EVAL
move_done  out  1  one-cycle pulse when a move resolves
result  out  3  0 MOVED, 1 BLOCKED, 2 LAVA, 3 TELEPORT, 4 WIN, 5 OFFGRID; held until next move_done
won  out  1  sticky win flag
deaths  out  DEATH_W  lava death count, saturating

Behaviour:
- Reset values (async, reset_n=0):
  - state IDLE; col=0, row=0; probe=(16,15).
  - busy=0, move_done=0, result=MOVED, won=0, deaths=0.
- Probe pixel: x = col*CELL_W + CELL_W/2; y = row*CELL_H + CELL_H/2. Computed with shifts/adds, no multipliers. In IDLE the probe holds the player's own cell centre.
- IDLE:
  - Nonzero move_req while won=0 starts a move.
  - If several bits are set, priority is up > down > left > right.
  - Candidate = position ±1.
  - Candidate off-grid (row<0, row>=ROWS, col<0, col>=COLS): no probe. move_done pulses next cycle with result=OFFGRID; stay in IDLE.
  - Otherwise load the candidate probe and go to PROBE.
- PROBE (1 cycle): map flags settle combinationally. Register all nine flags; go to EVAL.
- EVAL (1 cycle): resolve using the registered flags, in priority order wall > lava > finish > teleport > plain.
  - wall: position unchanged, BLOCKED.
  - lava: position=(0,0), deaths+1 (saturating at all-ones), LAVA.
  - finish: position=candidate, won=1, WIN.
  - teleport colour c: position = the partner cell of c (the cell of the pair that is not the candidate), TELEPORT. No chaining, no re-probe.
  - none: position=candidate, MOVED.
  - In all cases: move_done=1, probe reloaded to the new own-cell centre, return to IDLE.
- Latency: request in cycle N → probe valid N+1 → move_done and new position visible in N+3 (registered outputs).
- move_req is ignored while busy or won. No queuing.
- restart:
  - Has priority over move_req in the same cycle.
  - Aborts PROBE/EVAL with no move_done, sets position=(0,0), won=0, IDLE.
  - deaths is kept; it is cleared only by reset_n.
- reset_n asserted mid-move: immediate return to reset values.

Decomposition:
- Package maze_pkg holds:
  - grid constants (CELL_W, CELL_H, COLS, ROWS);
  - result enum;
  - state enum (IDLE, PROBE, EVAL);
  - start cell (0,0) and finish cell (17,13);
  - teleport pair table, each entry a (col,row) pair:
    - pink (7,5)/(13,1)
    - green (13,3)/(1,8)
    - cyan (0,15)/(8,8)
    - purple (9,8)/(11,14)
    - grey (17,12)/(17,14)
- One sub-module, cell_to_pixel: col/row to centre pixel. Shared with the renderer.

Test Plan:
- Reset, then up from (0,0) → no probe change; move_done pulses with result=OFFGRID; position stays (0,0).
- With the real map, right from (0,0) → probe (48,15), walls=1 → BLOCKED, position (0,0), move_done at N+3.
- With the real map, down ×7 from (0,0) → rows 1–6 MOVED; row 7 probe (16,225) hits lava → LAVA, position (0,0), deaths=1.
- With a stub map, at (7,4) press down → probe (240,165), stub asserts teleport_pink → TELEPORT, position (13,1); move_done pulses once only.
- With a stub map, finish_line=1 on a move into (17,13) → WIN, won=1. Later move_req leaves the probe and position unchanged. Then restart → (0,0), won=0, deaths unchanged.
- move_req=4'b1111 at (0,1) → up is chosen, probe (16,15). Assert restart during PROBE → no move_done, position (0,0). Pulse reset_n low during EVAL → all outputs return to reset values immediately.
